// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU port (0) and a loader/DMA/debug port (1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a starvation guard.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starve_evt
);

    logic both_valid;
    logic grant0;
    logic grant1;
    logic starve;
    logic acc0;
    logic acc1;

    assign both_valid = req0_valid & req1_valid;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr names the port that wins the next contended cycle
    always_comb begin
        starve = 1'b0;
        grant0 = req0_valid;
        grant1 = req1_valid;
        if (both_valid) begin
            grant0 = ~rr_ptr;
            grant1 = rr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (both_valid) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    always_comb begin
        starve = both_valid && (wait_cnt == WAIT_LIMIT);
        grant1 = req1_valid & (~req0_valid | starve);
        grant0 = req0_valid & ~grant1;
    end

    // Counts consecutive cycles port 1 has been kept waiting; saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!req1_valid || grant1) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign starve_evt = starve & rst_n;

    // With no grant the port 0 request still drives address and data
    assign mem_addr  = grant1 ? req1_addr  : req0_addr;
    assign mem_wdata = grant1 ? req1_wdata : req0_wdata;
    assign mem_we    = rst_n & ((grant0 & req0_we) | (grant1 & req1_we));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= acc0;
            rsp1_valid <= acc1;
            if (acc0 && !req0_we) begin
                rsp0_rdata <= mem_rdata;
            end
            if (acc1 && !req1_we) begin
                rsp1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run against
// a behavioural model. Follows DMEM_ARB_RR_EN to pick the expected arbitration policy.
module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, starve_evt;

    bit   [31:0] mem     [0:63];
    bit   [31:0] ref_mem [0:63];
    int          total = 0;
    int          bad   = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .starve_evt(starve_evt)
    );

    always #5 clk = ~clk;

    // Word-addressed memory seen by the arbiter: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    endtask

    task test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h44; req0_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready0: got %b want 0", req0_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
        total++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata: got %h/%h want 0/0", rsp0_rdata, rsp1_rdata); end
        total++; if (starve_evt !== 1'b0) begin bad++; $display("[TB] FAIL rst_starve: got %b want 0", starve_evt); end
        rst_n = 1'b1;
        req0_we = 1'b0;
        #2;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_rel_ready0: got %b want 1", req0_ready); end
        @(posedge clk); #1;
        idle_inputs();
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_drop_rsp0: got %b want 0", rsp0_valid); end
        total++; if (req0_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_gate: got ready0=%b we=%b want 0/0", req0_ready, mem_we); end
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_after: got v=%b d=%h want 0/0", rsp0_valid, rsp0_rdata); end
    endtask

    task test_contention();
        logic exp1, exp_st;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h00;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h04;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            exp1 = (k % 2) == 1;
            exp_st = 1'b0;
`else
            exp1 = (k % 5) == 4;
            exp_st = exp1;
`endif
            total++; if (req1_ready !== exp1 || req0_ready !== !exp1) begin bad++; $display("[TB] FAIL contend_grant k=%0d: got r0=%b r1=%b want r1=%b", k, req0_ready, req1_ready, exp1); end
            total++; if (starve_evt !== exp_st) begin bad++; $display("[TB] FAIL contend_starve k=%0d: got %b want %b", k, starve_evt, exp_st); end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task test_write_read();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h10; req0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("[TB] FAIL wr_grant: got ready=%b we=%b want 1/1", req0_ready, mem_we); end
        total++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL wr_bus: got %h/%h want 00000010/deadbeef", mem_addr, mem_wdata); end
        @(posedge clk); #1;
        req0_we = 1'b0;
        @(negedge clk);
        total++; if (mem_we !== 1'b0 || rsp0_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack: got we=%b rsp0_valid=%b want 0/1", mem_we, rsp0_valid); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_data: got v=%b d=%h want 1/deadbeef", rsp0_valid, rsp0_rdata); end
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_single: got %b want 0", rsp0_valid); end
    endtask

    task test_port1_read();
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req1_we = 1'b0;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL p1_ready: got r1=%b r0=%b want 1/0", req1_ready, req0_ready); end
        total++; if (mem_addr !== 32'h20 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL p1_bus: got %h we=%b want 00000020/0", mem_addr, mem_we); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin bad++; $display("[TB] FAIL p1_rsp: got v1=%b v0=%b want 1/0", rsp1_valid, rsp0_valid); end
        total++; if (rsp1_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL p1_rdata: got %h want 12345678", rsp1_rdata); end
    endtask

    task test_same_addr();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h30; req0_wdata = 32'hCAFE_F00D;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h30;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("[TB] FAIL same_first: got r0=%b r1=%b we=%b want 1/0/1", req0_ready, req1_ready, mem_we); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_we = 1'b0;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1 || mem_we !== 1'b0 || rsp0_valid !== 1'b1) begin bad++; $display("[TB] FAIL same_second: got r1=%b we=%b rsp0=%b want 1/0/1", req1_ready, mem_we, rsp0_valid); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL same_rdata: got v=%b d=%h want 1/cafef00d", rsp1_valid, rsp1_rdata); end
    endtask

    // Model: port 1 may lose at most MAX_WAIT contended cycles in a row (fixed priority),
    // or the two ports take turns on contention (round robin).
    task test_random();
        logic        p0v, p0we, p1v, p1we, acc0, acc1, ev0, ev1, exp_we, exp_st;
        logic [31:0] p0a, p0d, p1a, p1d, ed0, ed1, exp_addr, exp_wdata;
        int          g, losses, last_win;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem = mem;
        losses = 0; last_win = 1;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
        p0v = 1'b0; p1v = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        p0we = 1'b0; p1we = 1'b0; p0a = 32'h0; p1a = 32'h0; p0d = 32'h0; p1d = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (!p0v || acc0) begin
                p0v = $urandom_range(0, 99) < 55; p0we = $urandom_range(0, 1) == 1;
                p0a = 32'($urandom_range(0, 255)); p0d = $urandom;
            end
            if (!p1v || acc1) begin
                p1v = $urandom_range(0, 99) < 65; p1we = $urandom_range(0, 1) == 1;
                p1a = 32'($urandom_range(0, 255)); p1d = $urandom;
            end
            req0_valid = p0v; req0_we = p0we; req0_addr = p0a; req0_wdata = p0d;
            req1_valid = p1v; req1_we = p1we; req1_addr = p1a; req1_wdata = p1d;
            @(negedge clk);
            exp_st = 1'b0;
            if (p0v && p1v) begin
`ifdef DMEM_ARB_RR_EN
                g = 1 - last_win;
                last_win = g;
`else
                g = (losses == MAX_WAIT) ? 1 : 0;
                exp_st = (g == 1);
`endif
            end else if (p0v) begin
                g = 0;
            end else if (p1v) begin
                g = 1;
            end else begin
                g = -1;
            end
            exp_addr  = (g == 1) ? p1a : p0a;
            exp_wdata = (g == 1) ? p1d : p0d;
            exp_we    = (g == 0) ? p0we : ((g == 1) ? p1we : 1'b0);
            total++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin bad++; $display("[TB] FAIL rnd_grant c=%0d: got r0=%b r1=%b want grant=%0d", cyc, req0_ready, req1_ready, g); end
            total++; if (mem_we !== exp_we) begin bad++; $display("[TB] FAIL rnd_we c=%0d: got %b want %b", cyc, mem_we, exp_we); end
            total++; if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin bad++; $display("[TB] FAIL rnd_bus c=%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, exp_addr, exp_wdata); end
            total++; if (starve_evt !== exp_st) begin bad++; $display("[TB] FAIL rnd_starve c=%0d: got %b want %b", cyc, starve_evt, exp_st); end
            total++; if (rsp0_valid !== ev0 || rsp0_rdata !== ed0) begin bad++; $display("[TB] FAIL rnd_rsp0 c=%0d: got %b/%h want %b/%h", cyc, rsp0_valid, rsp0_rdata, ev0, ed0); end
            total++; if (rsp1_valid !== ev1 || rsp1_rdata !== ed1) begin bad++; $display("[TB] FAIL rnd_rsp1 c=%0d: got %b/%h want %b/%h", cyc, rsp1_valid, rsp1_rdata, ev1, ed1); end
            acc0 = (g == 0);
            acc1 = (g == 1);
            ev0 = acc0;
            ev1 = acc1;
            if (acc0 && !p0we) ed0 = ref_mem[p0a[7:2]];
            if (acc1 && !p1we) ed1 = ref_mem[p1a[7:2]];
            if (acc0 && p0we) ref_mem[p0a[7:2]] = p0d;
            if (acc1 && p1we) ref_mem[p1a[7:2]] = p1d;
            if (!p1v || acc1) losses = 0;
            else if (losses < MAX_WAIT) losses++;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        $display("[TB] starting dmem_port_arbiter bench");
        test_reset();
        test_contention();
        test_write_read();
        test_port1_read();
        test_same_addr();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
